ps2_rx_fifo: RTL and testbench
==============================

PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, number of byte entries (power of two, 2..16).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 2000, idle clk cycles between PS/2 falling edges before an in-progress frame is abandoned.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port ps2_clk  input  1  raw PS/2 clock pin, asynchronous to clk.
REQ-006 SHALL have port ps2_data  input  1  raw PS/2 data pin, asynchronous to clk.
REQ-007 SHALL have port clr  input  1  pop request level from the 68k bus interface, high for the duration of a read cycle.
REQ-008 SHALL have port err_clr  input  1  single-cycle pulse clearing the sticky error flags.
REQ-009 SHALL have port read_reg  output  8  FIFO head byte, feeds the bus interface read register.
REQ-010 SHALL have port rx_valid  output  1  high while FIFO is non-empty.
REQ-011 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  number of stored bytes.
REQ-012 SHALL have port overflow  output  1  sticky, a good byte was dropped because the FIFO was full.
REQ-013 SHALL have port frame_err  output  1  sticky, parity error or stop bit 0 seen.

Function
REQ-014 SHALL pass ps2_clk and ps2_data through 2-FF synchronizers; falling edge = registered synced clk 1, synced clk 0 (3 clk cycles pin-to-detect).
REQ-015 SHALL run an FSM with states IDLE, DATA, PARITY, STOP, advancing only on a detected falling edge, sampling synced ps2_data.
REQ-016 IDLE: data 0 -> DATA with bit count 0; data 1 -> stay IDLE, no effect.
REQ-017 DATA: shift in LSB first (new bit enters bit 7, shift right); after 8th bit -> PARITY.
REQ-018 PARITY: capture parity bit -> STOP.
REQ-019 STOP: good frame = stop bit 1 and XOR of 8 data bits and parity bit equals 1 (odd parity); good -> push byte; else set frame_err, discard; always -> IDLE.
REQ-020 In DATA/PARITY/STOP, a cycle counter SHALL reset on each falling edge; reaching TIMEOUT_CYCLES returns FSM to IDLE, discards partial byte, sets no flag.
REQ-021 Pop SHALL occur on the rising edge of clr (clr high, registered clr low), exactly once per read cycle regardless of clr length; pop when empty is ignored.
REQ-022 read_reg SHALL equal head entry combinationally from FIFO storage; 8'h00 when empty.
REQ-023 Pushed byte SHALL appear on read_reg/rx_valid the cycle after the STOP-bit edge is detected.
REQ-024 Push while full and no pop: byte dropped, overflow set, contents unchanged.
REQ-025 Push and pop same cycle: when full, both succeed, count unchanged, no overflow; when empty, push succeeds, pop ignored, count becomes 1.
REQ-026 Read/write pointers SHALL wrap modulo FIFO_DEPTH; order strictly first-in first-out.
REQ-027 err_clr SHALL clear overflow and frame_err; a new error in the same cycle wins (flag stays 1).

Reset
REQ-028 On reset: FSM IDLE, bit count and timeout counter 0, shift register 0, FIFO empty (pointers 0, fifo_count 0), rx_valid 0, read_reg 8'h00, overflow 0, frame_err 0.
REQ-029 Synchronizer and edge registers SHALL reset to 1 (idle line) so reset release creates no false edge.
REQ-030 Reset mid-frame SHALL abandon the frame; following bits up to next start bit after return to IDLE are ignored via REQ-016.

Structure
REQ-031 Package ps2_pkg SHALL hold the FSM state enum, frame length constants (8 data bits, 11-bit frame) and default TIMEOUT_CYCLES.
REQ-032 FIFO SHALL be a sub-module sync_fifo (parameter DEPTH, width 8, push/pop/full/empty/count, same reset); receiver FSM stays in ps2_rx_fifo.

Verification
REQ-033 Send frame 0x1C, parity 0, stop 1 -> read_reg 8'h1C, rx_valid 1, fifo_count 1, frame_err 0.
REQ-034 Send 0xF0 with parity 0 (bad) -> nothing pushed, frame_err 1; err_clr pulse -> frame_err 0.
REQ-035 Send 9 good bytes 0x01..0x09 with no clr (DEPTH 8) -> fifo_count 8, overflow 1, read_reg 8'h01; pop 8 times -> 0x01..0x08 in order, rx_valid 0 after last.
REQ-036 Hold clr high 20 cycles with 2 bytes stored -> exactly one pop, fifo_count 1.
REQ-037 Send start + 4 data bits then idle > TIMEOUT_CYCLES, then full frame 0x5A -> only 0x5A stored, no flags.
REQ-038 FIFO full, pop and push coincide -> fifo_count stays 8, overflow 0, new byte last in order.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: FSM states, frame geometry
// and the odd-parity check used at the stop bit.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    localparam int PS2_DATA_BITS       = 8;
    localparam int PS2_FRAME_BITS      = 11;
    localparam int PS2_DEFAULT_TIMEOUT = 2000;

    // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Byte-wide synchronous FIFO; a pop on empty is ignored and a push on full only
// lands when a pop frees a slot in the same cycle.
module sync_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic          do_push_s;
    logic          do_pop_s;

    // Accept/refuse logic for push and pop requests.
    always_comb begin
        do_pop_s  = pop && (count_r != '0);
        do_push_s = push && ((count_r != (AW+1)'(DEPTH)) || do_pop_s);
    end

    // Storage write; contents need no reset since reads are gated by empty.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + {{AW{1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{AW{1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

    assign empty = (count_r == '0);
    assign full  = (count_r == (AW+1)'(DEPTH));
    assign count = count_r;
    assign dout  = empty ? 8'h00 : mem_r[rd_ptr_r];

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronises the pins, decodes 11-bit frames
// and queues good bytes for the 68k bus interface.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = PS2_DEFAULT_TIMEOUT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    input  logic                          clr,
    input  logic                          err_clr,
    output logic [7:0]                    read_reg,
    output logic                          rx_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          ps2_clk_s1_r, ps2_clk_s2_r, ps2_clk_prev_r;
    logic          ps2_data_s1_r, ps2_data_s2_r;
    logic          clr_prev_r;
    logic          fall_s, pop_s;
    ps2_state_t    state_r, state_n;
    logic [2:0]    bit_cnt_r, bit_cnt_n;
    logic [7:0]    shift_r, shift_n;
    logic          parity_r, parity_n;
    logic [TW-1:0] tmo_cnt_r, tmo_cnt_n;
    logic          push_s, bad_frame_s, ovf_evt_s;
    logic          fifo_full_s, fifo_empty_s;
    logic          overflow_r, frame_err_r;

    // Pin synchronisers and edge history; idle-high reset avoids a false edge at release.
    always_ff @(posedge clk) begin
        if (reset) begin
            ps2_clk_s1_r   <= 1'b1;
            ps2_clk_s2_r   <= 1'b1;
            ps2_clk_prev_r <= 1'b1;
            ps2_data_s1_r  <= 1'b1;
            ps2_data_s2_r  <= 1'b1;
            clr_prev_r     <= 1'b0;
        end else begin
            ps2_clk_s1_r   <= ps2_clk;
            ps2_clk_s2_r   <= ps2_clk_s1_r;
            ps2_clk_prev_r <= ps2_clk_s2_r;
            ps2_data_s1_r  <= ps2_data;
            ps2_data_s2_r  <= ps2_data_s1_r;
            clr_prev_r     <= clr;
        end
    end

    assign fall_s = ps2_clk_prev_r & ~ps2_clk_s2_r;
    assign pop_s  = clr & ~clr_prev_r;

    // Receiver FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'h00;
            parity_r  <= 1'b0;
            tmo_cnt_r <= '0;
        end else begin
            state_r   <= state_n;
            bit_cnt_r <= bit_cnt_n;
            shift_r   <= shift_n;
            parity_r  <= parity_n;
            tmo_cnt_r <= tmo_cnt_n;
        end
    end

    // Frame decoding; a stalled frame is silently dropped by the inactivity timer.
    always_comb begin
        state_n     = state_r;
        bit_cnt_n   = bit_cnt_r;
        shift_n     = shift_r;
        parity_n    = parity_r;
        tmo_cnt_n   = '0;
        push_s      = 1'b0;
        bad_frame_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (fall_s && !ps2_data_s2_r) begin
                    state_n   = ST_DATA;
                    bit_cnt_n = 3'd0;
                end else begin
                    state_n   = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (fall_s) begin
                    shift_n   = {ps2_data_s2_r, shift_r[7:1]};
                    bit_cnt_n = bit_cnt_r + 3'd1;
                    if (bit_cnt_r == 3'd7) begin
                        state_n = ST_PARITY;
                    end else begin
                        state_n = ST_DATA;
                    end
                end else begin
                    state_n = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (fall_s) begin
                    parity_n = ps2_data_s2_r;
                    state_n  = ST_STOP;
                end else begin
                    state_n  = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (fall_s) begin
                    if (ps2_data_s2_r && odd_parity_ok(shift_r, parity_r)) begin
                        push_s = 1'b1;
                    end else begin
                        bad_frame_s = 1'b1;
                    end
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_STOP;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        if (state_r != ST_IDLE) begin
            if (fall_s) begin
                tmo_cnt_n = '0;
            end else if (tmo_cnt_r == TW'(TIMEOUT_CYCLES)) begin
                state_n   = ST_IDLE;
                bit_cnt_n = 3'd0;
                shift_n   = 8'h00;
                tmo_cnt_n = '0;
            end else begin
                tmo_cnt_n = tmo_cnt_r + {{(TW-1){1'b0}}, 1'b1};
            end
        end else begin
            tmo_cnt_n = '0;
        end
    end

    assign ovf_evt_s = push_s && fifo_full_s && !pop_s;

    // Sticky error flags; a fresh error outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_r  <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            if (ovf_evt_s) begin
                overflow_r <= 1'b1;
            end else if (err_clr) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
            if (bad_frame_s) begin
                frame_err_r <= 1'b1;
            end else if (err_clr) begin
                frame_err_r <= 1'b0;
            end else begin
                frame_err_r <= frame_err_r;
            end
        end
    end

    sync_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .din   (shift_r),
        .dout  (read_reg),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count)
    );

    assign rx_valid  = ~fifo_empty_s;
    assign overflow  = overflow_r;
    assign frame_err = frame_err_r;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: bit-banged PS/2 frames with hand-computed
// expected FIFO contents and flags.
module tb_ps2_rx_fifo;

    logic       clk;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic       clr;
    logic       err_clr;
    logic [7:0] read_reg;
    logic       rx_valid;
    logic [3:0] fifo_count;
    logic       overflow;
    logic       frame_err;

    int n_cmp = 0;
    int n_err = 0;
    logic [3:0] lat_a;
    logic [3:0] lat_b;

    ps2_rx_fifo #(
        .FIFO_DEPTH     (8),
        .TIMEOUT_CYCLES (2000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .clr        (clr),
        .err_clr    (err_clr),
        .read_reg   (read_reg),
        .rx_valid   (rx_valid),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic odd_par(input logic [7:0] d);
        return ~^d;
    endfunction

    // Sends one frame; optionally raises clr so the pop lands with the stop-bit push.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic stop, input logic pop_at_stop);
        logic [10:0] fr;
        fr = {stop, p, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            ps2_data = fr[i];
            wait_cyc(10);
            ps2_clk = 1'b0;
            if (i == 10) begin
                wait_cyc(2);
                lat_a = fifo_count;
                if (pop_at_stop) clr = 1'b1;
                wait_cyc(1);
                lat_b = fifo_count;
                clr = 1'b0;
                wait_cyc(7);
            end else begin
                wait_cyc(10);
            end
            ps2_clk = 1'b1;
        end
        wait_cyc(5);
    endtask

    task automatic send_good(input logic [7:0] d);
        send_frame(d, odd_par(d), 1'b1, 1'b0);
    endtask

    task automatic send_partial(input int nbits);
        for (int i = 0; i <= nbits; i++) begin
            @(negedge clk);
            ps2_data = (i == 0) ? 1'b0 : 1'b1;
            wait_cyc(10);
            ps2_clk = 1'b0;
            wait_cyc(10);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic pop_once(input string tag, input logic [7:0] exp);
        check_eq(tag, {24'h0, read_reg}, {24'h0, exp});
        @(negedge clk);
        clr = 1'b1;
        wait_cyc(3);
        clr = 1'b0;
        wait_cyc(2);
    endtask

    initial begin
        reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; clr = 1'b0; err_clr = 1'b0;
        wait_cyc(5);
        check_eq("rst_read_reg", {24'h0, read_reg}, 32'h0);
        check_eq("rst_rx_valid", {31'h0, rx_valid}, 32'h0);
        check_eq("rst_count", {28'h0, fifo_count}, 32'h0);
        check_eq("rst_overflow", {31'h0, overflow}, 32'h0);
        check_eq("rst_frame_err", {31'h0, frame_err}, 32'h0);
        reset = 1'b0;
        wait_cyc(5);

        // Single good frame 0x1C (three ones -> parity 0)
        send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
        check_eq("lat_before", {28'h0, lat_a}, 32'h0);
        check_eq("lat_after", {28'h0, lat_b}, 32'h1);
        check_eq("f1c_read", {24'h0, read_reg}, 32'h1C);
        check_eq("f1c_valid", {31'h0, rx_valid}, 32'h1);
        check_eq("f1c_count", {28'h0, fifo_count}, 32'h1);
        check_eq("f1c_ferr", {31'h0, frame_err}, 32'h0);
        pop_once("f1c_pop", 8'h1C);
        check_eq("f1c_empty", {31'h0, rx_valid}, 32'h0);

        // Bad parity on 0xF0
        send_frame(8'hF0, 1'b0, 1'b1, 1'b0);
        check_eq("bad_count", {28'h0, fifo_count}, 32'h0);
        check_eq("bad_ferr", {31'h0, frame_err}, 32'h1);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        check_eq("bad_ferr_clr", {31'h0, frame_err}, 32'h0);

        // Overflow: nine bytes into depth 8
        for (int i = 1; i <= 9; i++) send_good(8'(i));
        check_eq("ovf_count", {28'h0, fifo_count}, 32'h8);
        check_eq("ovf_flag", {31'h0, overflow}, 32'h1);
        check_eq("ovf_head", {24'h0, read_reg}, 32'h01);
        for (int i = 1; i <= 8; i++) pop_once("ovf_order", 8'(i));
        check_eq("ovf_drained", {31'h0, rx_valid}, 32'h0);
        check_eq("ovf_drain_rd", {24'h0, read_reg}, 32'h0);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        check_eq("ovf_clr", {31'h0, overflow}, 32'h0);

        // Long clr level pops exactly once
        send_good(8'h33);
        send_good(8'h44);
        @(negedge clk); clr = 1'b1;
        wait_cyc(20);
        clr = 1'b0;
        wait_cyc(2);
        check_eq("long_clr_count", {28'h0, fifo_count}, 32'h1);
        pop_once("long_clr_head", 8'h44);

        // Abandoned partial frame, then a good 0x5A
        send_partial(4);
        wait_cyc(2100);
        send_good(8'h5A);
        check_eq("tmo_count", {28'h0, fifo_count}, 32'h1);
        check_eq("tmo_read", {24'h0, read_reg}, 32'h5A);
        check_eq("tmo_ferr", {31'h0, frame_err}, 32'h0);
        check_eq("tmo_ovf", {31'h0, overflow}, 32'h0);
        pop_once("tmo_pop", 8'h5A);

        // Full FIFO with coincident push and pop
        for (int i = 0; i < 8; i++) send_good(8'(8'h10 + i));
        check_eq("full_count", {28'h0, fifo_count}, 32'h8);
        send_frame(8'h18, odd_par(8'h18), 1'b1, 1'b1);
        check_eq("coinc_before", {28'h0, lat_a}, 32'h8);
        check_eq("coinc_after", {28'h0, lat_b}, 32'h8);
        check_eq("coinc_count", {28'h0, fifo_count}, 32'h8);
        check_eq("coinc_ovf", {31'h0, overflow}, 32'h0);
        for (int i = 1; i <= 8; i++) pop_once("coinc_order", 8'(8'h10 + i));
        check_eq("coinc_empty", {31'h0, rx_valid}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
